md_issue_decode: RTL and testbench

- Registered decode stage for the 5-stage MIPS pipeline. It sits between IF/ID and EX.
- Decodes the MIPS-I integer set plus SYSCALL/BREAK/ERET and registers control outputs behind a valid/ready handshake.
- Sequences multi-cycle MULT/DIV issue with a latency counter, and interlocks HI/LO accesses until the operation completes.
- Flags reserved-instruction and trap exceptions.

---
 rtl/md_issue_decode.sv | 196 +++++++++++++++++++
 tb/tb_md_issue_decode.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_decode.sv
// Registered MIPS-I decode stage with MULT/DIV issue sequencing and HI/LO interlock.
// Latency 1 cycle; in_ready drops while EX stalls or while a HI/LO access must wait on MD.
module md_issue_decode #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      inst,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [3:0]       ALUop,
    output logic [3:0]       RegWrite,
    output logic             MemEn,
    output logic [3:0]       MemWrite,
    output logic [1:0]       MFHL,
    output logic [1:0]       MTHL,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             md_busy,
    output logic             exc_valid,
    output logic [4:0]       exc_code,
    output logic             eret
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    logic [5:0] op, func;
    logic [4:0] rt;
    assign op   = inst[31:26];
    assign func = inst[5:0];
    assign rt   = inst[20:16];

    logic [3:0] d_alu, d_rw, d_mw;
    logic       d_memen, d_md, d_ri, d_sys, d_bp, d_eret, d_exc;
    logic [1:0] d_mfhl, d_mthl, d_mdop;
    logic [4:0] d_code;

    always_comb begin
        d_alu   = ALU_AND;
        d_rw    = 4'h0;
        d_memen = 1'b0;
        d_mw    = 4'h0;
        d_mfhl  = 2'b00;
        d_mthl  = 2'b00;
        d_md    = 1'b0;
        d_mdop  = 2'b00;
        d_ri    = 1'b0;
        d_sys   = 1'b0;
        d_bp    = 1'b0;
        d_eret  = 1'b0;
        case (op)
            6'b000000: begin
                case (func)
                    6'b000000, 6'b000100: begin d_alu = ALU_SLL; d_rw = 4'hF; end
                    6'b000010, 6'b000110: begin d_alu = ALU_SRL; d_rw = 4'hF; end
                    6'b000011, 6'b000111: begin d_alu = ALU_SRA; d_rw = 4'hF; end
                    6'b001000: ;
                    6'b001001: begin d_alu = ALU_ADD; d_rw = 4'hF; end
                    6'b001100: d_sys = 1'b1;
                    6'b001101: d_bp  = 1'b1;
                    6'b010000: begin d_mfhl = 2'b10; d_rw = 4'hF; end
                    6'b010001: d_mthl = 2'b10;
                    6'b010010: begin d_mfhl = 2'b01; d_rw = 4'hF; end
                    6'b010011: d_mthl = 2'b01;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        d_md   = 1'b1;
                        d_mdop = func[1:0];
                    end
                    6'b100000, 6'b100001: begin d_alu = ALU_ADD;  d_rw = 4'hF; end
                    6'b100010, 6'b100011: begin d_alu = ALU_SUB;  d_rw = 4'hF; end
                    6'b100100: begin d_alu = ALU_AND;  d_rw = 4'hF; end
                    6'b100101: begin d_alu = ALU_OR;   d_rw = 4'hF; end
                    6'b100110: begin d_alu = ALU_XOR;  d_rw = 4'hF; end
                    6'b100111: begin d_alu = ALU_NOR;  d_rw = 4'hF; end
                    6'b101010: begin d_alu = ALU_SLT;  d_rw = 4'hF; end
                    6'b101011: begin d_alu = ALU_SLTU; d_rw = 4'hF; end
                    default:   d_ri = 1'b1;
                endcase
            end
            6'b000001: begin
                case (rt)
                    5'b00000, 5'b00001: ;
                    5'b10000, 5'b10001: begin d_alu = ALU_ADD; d_rw = 4'hF; end
                    default: d_ri = 1'b1;
                endcase
            end
            6'b000010: ;
            6'b000011: begin d_alu = ALU_ADD; d_rw = 4'hF; end
            6'b000100, 6'b000101: d_alu = ALU_SUB;
            6'b000110, 6'b000111: ;
            6'b001000, 6'b001001: begin d_alu = ALU_ADD;  d_rw = 4'hF; end
            6'b001010: begin d_alu = ALU_SLT;  d_rw = 4'hF; end
            6'b001011: begin d_alu = ALU_SLTU; d_rw = 4'hF; end
            6'b001100: begin d_alu = ALU_AND;  d_rw = 4'hF; end
            6'b001101: begin d_alu = ALU_OR;   d_rw = 4'hF; end
            6'b001110: begin d_alu = ALU_XOR;  d_rw = 4'hF; end
            6'b001111: begin d_alu = ALU_LUI;  d_rw = 4'hF; end
            // COP0: only the canonical ERET encoding is accepted
            6'b010000: begin
                if (inst[25] && inst[24:6] == 19'd0 && func == 6'b011000)
                    d_eret = 1'b1;
                else
                    d_ri = 1'b1;
            end
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110: begin
                d_alu = ALU_ADD; d_rw = 4'hF; d_memen = 1'b1;
            end
            6'b101000: begin d_alu = ALU_ADD; d_memen = 1'b1; d_mw = 4'b0001; end
            6'b101001: begin d_alu = ALU_ADD; d_memen = 1'b1; d_mw = 4'b0011; end
            6'b101010, 6'b101011, 6'b101110: begin
                d_alu = ALU_ADD; d_memen = 1'b1; d_mw = 4'b1111;
            end
            default: d_ri = 1'b1;
        endcase
    end

    assign d_exc  = d_ri | d_sys | d_bp;
    assign d_code = d_sys ? 5'd8 : d_bp ? 5'd9 : d_ri ? 5'd10 : 5'd0;

    logic             held_md;
    logic [CNT_W-1:0] md_cnt;
    logic             hilo_use, hazard, accept;

    // A HI/LO consumer must also wait while an un-issued MD op sits in the register
    assign hilo_use = d_md | (|d_mfhl) | (|d_mthl);
    assign md_busy  = (md_cnt != '0);
    assign hazard   = hilo_use & (md_busy | (out_valid & held_md));
    assign in_ready = ~rst & (~out_valid | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready & ~flush;
    assign md_start = out_valid & out_ready & held_md & ~exc_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ALUop     <= '0;
            RegWrite  <= '0;
            MemEn     <= 1'b0;
            MemWrite  <= '0;
            MFHL      <= '0;
            MTHL      <= '0;
            md_op     <= '0;
            held_md   <= 1'b0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            eret      <= 1'b0;
            md_cnt    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                ALUop     <= d_alu;
                RegWrite  <= d_exc ? 4'h0 : d_rw;
                MemEn     <= d_memen & ~d_exc;
                MemWrite  <= d_exc ? 4'h0 : d_mw;
                MFHL      <= d_mfhl;
                MTHL      <= d_exc ? 2'b00 : d_mthl;
                md_op     <= d_mdop;
                held_md   <= d_md & ~d_exc;
                exc_valid <= d_exc;
                exc_code  <= d_code;
                eret      <= d_eret;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
                held_md   <= 1'b0;
                exc_valid <= 1'b0;
                exc_code  <= '0;
            end

            // An issued MD op always runs to completion, flush or not
            if (md_start)
                md_cnt <= md_op[1] ? DIV_CNT : MUL_CNT;
            else if (md_busy)
                md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_md_issue_decode.sv
// Directed, table-driven bench for md_issue_decode with short DIV latency.
module tb_md_issue_decode;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [31:0] inst;
    logic        in_ready, out_valid, MemEn, md_start, md_busy, exc_valid, eret;
    logic [3:0]  ALUop, RegWrite, MemWrite;
    logic [1:0]  MFHL, MTHL, md_op;
    logic [4:0]  exc_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_issue_decode #(.MUL_LAT(2), .DIV_LAT(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .ALUop(ALUop), .RegWrite(RegWrite), .MemEn(MemEn), .MemWrite(MemWrite),
        .MFHL(MFHL), .MTHL(MTHL), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
        .exc_valid(exc_valid), .exc_code(exc_code), .eret(eret)
    );

    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_SW    = 32'hAC220004;
    localparam logic [31:0] I_OR    = 32'h00221825;
    localparam logic [31:0] I_AND   = 32'h00221824;
    localparam logic [31:0] I_DIV   = 32'h0022001A;
    localparam logic [31:0] I_MULT  = 32'h00220018;
    localparam logic [31:0] I_MULTU = 32'h00220019;
    localparam logic [31:0] I_MFLO  = 32'h00001812;
    localparam logic [31:0] I_RI    = 32'hFC000000;

    typedef struct {
        logic [31:0] inst;
        logic        alu_chk;
        logic [3:0]  alu;
        logic [3:0]  rw;
        logic        men;
        logic [3:0]  mw;
        logic [1:0]  mfhl;
        logic [1:0]  mthl;
        logic        exc;
        logic [4:0]  code;
        logic        eret;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present an instruction until accepted; leaves time at posedge+1 after the accept edge
    task automatic send(input logic [31:0] i, output bit ok);
        in_valid = 1'b1;
        inst = i;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] fields();
        return {RegWrite, MemEn, MemWrite, MFHL, MTHL, exc_valid, exc_code, eret};
    endfunction

    initial begin
        bit ok;
        logic [2:0] exp_c[6];
        logic [19:0] exp_f;
        int busy_n;

        vecs[0]  = '{I_ADDU,       1, 4'b0010, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[1]  = '{I_SW,         1, 4'b0010, 4'h0, 1, 4'hF, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[2]  = '{32'hA0220000, 1, 4'b0010, 4'h0, 1, 4'h1, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[3]  = '{32'hA4220000, 1, 4'b0010, 4'h0, 1, 4'h3, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[4]  = '{32'h8C220000, 1, 4'b0010, 4'hF, 1, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[5]  = '{32'h3C011234, 1, 4'b0011, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[6]  = '{32'h0022182B, 1, 4'b0100, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[7]  = '{32'h00011883, 1, 4'b1011, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[8]  = '{32'h00221806, 1, 4'b1100, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[9]  = '{32'h00221827, 1, 4'b1001, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[10] = '{32'h38220001, 1, 4'b1010, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[11] = '{32'h0C000010, 1, 4'b0010, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[12] = '{32'h04310004, 1, 4'b0010, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};
        vecs[13] = '{I_MFLO,       0, 4'b0000, 4'hF, 0, 4'h0, 2'b01, 2'b00, 0, 5'd0,  0};
        vecs[14] = '{32'h00200011, 0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b10, 0, 5'd0,  0};
        vecs[15] = '{I_RI,         0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b00, 1, 5'd10, 0};
        vecs[16] = '{32'h0000000C, 0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b00, 1, 5'd8,  0};
        vecs[17] = '{32'h0000000D, 0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b00, 1, 5'd9,  0};
        vecs[18] = '{32'h42000018, 0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  1};
        vecs[19] = '{32'h00000001, 0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b00, 1, 5'd10, 0};
        vecs[20] = '{32'h04020000, 0, 4'b0000, 4'h0, 0, 4'h0, 2'b00, 2'b00, 1, 5'd10, 0};
        vecs[21] = '{32'h00221822, 1, 4'b0110, 4'hF, 0, 4'h0, 2'b00, 2'b00, 0, 5'd0,  0};

        rst = 1'b1; in_valid = 1'b1; inst = I_ADDU; out_ready = 1'b1; flush = 1'b0;

        // Reset holds everything at zero and refuses input
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_md_busy", md_busy, 0);
            chk("rst_outputs", {fields(), ALUop, md_start, md_op}, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // addu then sw back to back
        in_valid = 1'b1; inst = I_ADDU;
        @(negedge clk);
        chk("addu_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        inst = I_SW;
        @(negedge clk);
        chk("addu_valid", out_valid, 1);
        chk("addu_alu", ALUop, 4'b0010);
        chk("addu_rw", RegWrite, 4'hF);
        chk("sw_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sw_valid", out_valid, 1);
        chk("sw_mem", {MemEn, MemWrite, RegWrite}, {1'b1, 4'hF, 4'h0});
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            send(vecs[i].inst, ok);
            chk($sformatf("v%0d_accept", i), ok, 1);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            if (vecs[i].alu_chk)
                chk($sformatf("v%0d_alu", i), ALUop, vecs[i].alu);
            exp_f = {vecs[i].rw, vecs[i].men, vecs[i].mw, vecs[i].mfhl, vecs[i].mthl,
                     vecs[i].exc, vecs[i].code, vecs[i].eret};
            chk($sformatf("v%0d_fields", i), fields(), exp_f);
        end

        // Backpressure: or held for 5 cycles, and must not be overwritten
        drain();
        out_ready = 1'b0;
        send(I_OR, ok);
        chk("bp_accept", ok, 1);
        in_valid = 1'b1; inst = I_AND;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_hold", c), {out_valid, ALUop, RegWrite, in_ready},
                {1'b1, 4'b0001, 4'hF, 1'b0});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_xfer", {out_valid, ALUop}, {1'b1, 4'b0001});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drop", out_valid, 0);

        // div then mflo: {md_start, md_busy, in_ready} per cycle
        drain();
        exp_c[0] = 3'b100; exp_c[1] = 3'b010; exp_c[2] = 3'b010;
        exp_c[3] = 3'b010; exp_c[4] = 3'b010; exp_c[5] = 3'b001;
        send(I_DIV, ok);
        chk("div_accept", ok, 1);
        in_valid = 1'b1; inst = I_MFLO;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("div_c%0d", c), {md_start, md_busy, in_ready}, exp_c[c]);
            if (c == 0) chk("div_md_op", md_op, 2'b10);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mflo_valid", out_valid, 1);
        chk("mflo_mfhl", {MFHL, RegWrite}, {2'b01, 4'hF});

        // Flush a held multu before it transfers
        drain();
        out_ready = 1'b0;
        send(I_MULTU, ok);
        chk("multu_accept", ok, 1);
        flush = 1'b1;
        @(negedge clk);
        chk("multu_held", {out_valid, md_start}, 2'b10);
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b1;
        busy_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) chk("flush_out_valid", out_valid, 0);
            if (md_start || md_busy) busy_n++;
            @(posedge clk);
            #1;
        end
        chk("flush_no_issue", busy_n, 0);

        // Flush clears a held exception
        drain();
        out_ready = 1'b0;
        send(I_RI, ok);
        chk("ri_accept", ok, 1);
        @(negedge clk);
        chk("ri_exc", {exc_valid, exc_code}, {1'b1, 5'd10});
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("ri_flushed", {out_valid, exc_valid, exc_code}, 7'd0);

        // Flush during an active div does not stop the counter
        drain();
        send(I_DIV, ok);
        chk("div2_accept", ok, 1);
        @(negedge clk);
        chk("div2_start", md_start, 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("div2_busy%0d", c), md_busy, (c < 5) ? 1 : 0);
            @(posedge clk);
            #1;
            flush = 1'b0;
        end

        // mult uses the short latency
        send(I_MULT, ok);
        chk("mult_accept", ok, 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mult_c%0d", c), {md_start, md_busy},
                (c == 0) ? 2'b10 : (c < 3) ? 2'b01 : 2'b00);
            if (c == 0) chk("mult_md_op", md_op, 2'b00);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
